// File: rtl/timer_ctrl_if.sv
// Command/status bundle between a timer_ctrl and its host: commands in, count and status out.
interface timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             mode;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
   logic             done;

   modport master (
      output start, stop, mode, limit,
      input  count, busy, tc, done
   );

   modport slave (
      input  start, stop, mode, limit,
      output count, busy, tc, done
   );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval timer: a prescaled up-counter sequenced through IDLE/RUN/DONE,
// with a registered one-clock terminal-count pulse and one-shot or auto-reload operation.
module timer_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic         clk,
   input  logic         rst,
   timer_ctrl_if.slave  tmr
);

   localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   limit_q, limit_d;
   logic [PSC_W-1:0]   psc_q,   psc_d;
   logic               mode_q,  mode_d;
   logic               tc_q,    tc_d;

   logic               accept;
   logic               tick;
   logic               terminal;

   // A start is honoured from IDLE or DONE; in RUN only stop is acted on.
   assign accept   = tmr.start && (state_q != RUN);
   assign tick     = (state_q == RUN) && (psc_q == PSC_MAX);
   assign terminal = tick && (count_q == limit_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         limit_q <= '0;
         psc_q   <= '0;
         mode_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         psc_q   <= psc_d;
         mode_q  <= mode_d;
         tc_q    <= tc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (tmr.start) state_d = RUN;
         end
         RUN: begin
            if (tmr.stop)                 state_d = IDLE;
            else if (terminal && !mode_q) state_d = DONE;
         end
         DONE: begin
            if (tmr.start)     state_d = RUN;
            else if (tmr.stop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stop in RUN freezes everything and swallows a coincident tick.
   always_comb begin
      count_d = count_q;
      limit_d = limit_q;
      psc_d   = psc_q;
      mode_d  = mode_q;
      tc_d    = 1'b0;
      if (accept) begin
         limit_d = tmr.limit;
         mode_d  = tmr.mode;
         count_d = '0;
         psc_d   = '0;
      end else if (state_q == RUN && !tmr.stop) begin
         if (tick) begin
            psc_d = '0;
            if (terminal) begin
               tc_d = 1'b1;
               if (mode_q) count_d = '0;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            psc_d = psc_q + PSC_W'(1);
         end
      end
   end

   always_comb begin
      tmr.busy  = (state_q == RUN);
      tmr.done  = (state_q == DONE);
      tmr.count = count_q;
      tmr.tc    = tc_q;
   end

endmodule
